// File: rtl/memctrl_host_seq.sv
// Command sequencer that turns valid/ready read/write commands into MEMCTRL pin-level SRAM cycles.
// Optional built-in-self-test hand-off is compiled in when MEMCTRL_SEQ_BIST_EN is defined.
module memctrl_host_seq #(
  parameter int CE_HALF = 1,
  parameter int AW      = 16,
  parameter int DW      = 8
`ifdef MEMCTRL_SEQ_BIST_EN
  , parameter int BIST_LEN = 1024
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_wr,
  output logic [DW-1:0] rsp_rdata,
  output logic [15:0]   txn_cnt,
  output logic          CSB,
  output logic          WEB,
  output logic          OEB,
  output logic          CE,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] IDATA,
  input  logic [DW-1:0] ODATA
`ifdef MEMCTRL_SEQ_BIST_EN
  , output logic        BIST_EN,
  output logic [2:0]    BIST_MODE,
  input  logic          BIST_PASS,
  input  logic          bist_req,
  input  logic [2:0]    bist_mode,
  output logic          bist_done,
  output logic          bist_result
`endif
);

  typedef enum logic [2:0] {
    IDLE, SETUP, CE1, CE1L, CE2, CE2L, RESP, BIST
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    ph_q, ph_d;
  logic          wr_q, wr_d;
  logic          csb_q, csb_d, web_q, web_d, oeb_q, oeb_d, ce_q, ce_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] idata_q, idata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [15:0]   txn_q, txn_d;
  logic          ph_last;

`ifdef MEMCTRL_SEQ_BIST_EN
  localparam int BCW = (BIST_LEN > 1) ? $clog2(BIST_LEN) : 1;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [2:0]     bmode_q, bmode_d;
  logic           bist_en_q, bist_en_d, bdone_q, bdone_d, bres_q, bres_d;
`endif

  assign ph_last = (ph_q == 4'(CE_HALF - 1));

  // Next state, then pin levels derived from the state being entered so every output is a flop.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    idata_d     = idata_q;
    rdata_d     = rdata_q;
    txn_d       = txn_q;
    csb_d       = csb_q;
    web_d       = web_q;
    oeb_d       = oeb_q;
    ce_d        = ce_q;
`ifdef MEMCTRL_SEQ_BIST_EN
    bcnt_d      = bcnt_q;
    bmode_d     = bmode_q;
    bres_d      = bres_q;
    bdone_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEMCTRL_SEQ_BIST_EN
        if (bist_req) begin
          state_d = BIST;
          bmode_d = bist_mode;
          bcnt_d  = '0;
        end else
`endif
        if (cmd_valid) begin
          state_d = SETUP;
          wr_d    = cmd_wr;
          addr_d  = cmd_addr;
          idata_d = cmd_wr ? cmd_wdata : '0;
          rdata_d = '0;
        end
      end
      SETUP: begin
        state_d = CE1;
        ph_d    = '0;
      end
      CE1, CE1L, CE2, CE2L: begin
        if (ph_last) begin
          ph_d = '0;
          case (state_q)
            CE1:     state_d = CE1L;
            CE1L:    state_d = CE2;
            CE2:     state_d = CE2L;
            default: state_d = RESP;
          endcase
          // Last OEB-low cycle of a read: sample the SRAM output here.
          if (state_q == CE1L && !wr_q) rdata_d = ODATA;
        end else begin
          ph_d = ph_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          txn_d   = txn_q + 16'd1;
        end
      end
`ifdef MEMCTRL_SEQ_BIST_EN
      BIST: begin
        if (bcnt_q == BCW'(BIST_LEN - 1)) begin
          state_d = IDLE;
          bres_d  = BIST_PASS;
          bdone_d = 1'b1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    case (state_d)
      SETUP: begin
        csb_d = 1'b0;
        web_d = ~wr_d;
        oeb_d = wr_d;
        ce_d  = 1'b0;
      end
      CE1: begin
        ce_d  = 1'b1;
        csb_d = 1'b0;
      end
      CE1L: begin
        ce_d  = 1'b0;
        csb_d = 1'b1;
        web_d = 1'b1;
      end
      CE2: begin
        ce_d  = 1'b1;
        oeb_d = 1'b1;
      end
      CE2L: ce_d = 1'b0;
      default: begin
        csb_d = 1'b1;
        web_d = 1'b1;
        oeb_d = 1'b1;
        ce_d  = 1'b0;
      end
    endcase

    rsp_valid_d = (state_d == RESP);
`ifdef MEMCTRL_SEQ_BIST_EN
    bist_en_d   = (state_d == BIST);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      wr_q        <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      oeb_q       <= 1'b1;
      ce_q        <= 1'b0;
      addr_q      <= '0;
      idata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      txn_q       <= '0;
`ifdef MEMCTRL_SEQ_BIST_EN
      bcnt_q      <= '0;
      bmode_q     <= '0;
      bist_en_q   <= 1'b0;
      bdone_q     <= 1'b0;
      bres_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      wr_q        <= wr_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      oeb_q       <= oeb_d;
      ce_q        <= ce_d;
      addr_q      <= addr_d;
      idata_q     <= idata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      txn_q       <= txn_d;
`ifdef MEMCTRL_SEQ_BIST_EN
      bcnt_q      <= bcnt_d;
      bmode_q     <= bmode_d;
      bist_en_q   <= bist_en_d;
      bdone_q     <= bdone_d;
      bres_q      <= bres_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE) && !RST;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = wr_q;
  assign rsp_rdata = rdata_q;
  assign txn_cnt   = txn_q;
  assign CSB       = csb_q;
  assign WEB       = web_q;
  assign OEB       = oeb_q;
  assign CE        = ce_q;
  assign ADDR      = addr_q;
  assign IDATA     = idata_q;
`ifdef MEMCTRL_SEQ_BIST_EN
  assign BIST_EN     = bist_en_q;
  assign BIST_MODE   = bmode_q;
  assign bist_done   = bdone_q;
  assign bist_result = bres_q;
`endif

endmodule

// File: tb/tb_memctrl_host_seq.sv
// Directed bench for memctrl_host_seq: two instances (CE_HALF=1 and CE_HALF=2), each with a small SRAM model.
module tb_memctrl_host_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Instance 1: CE_HALF = 1
  logic        cmd_valid, cmd_wr, rsp_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_wr;
  logic [7:0]  rsp_rdata;
  logic [15:0] txn_cnt;
  logic        csb, web, oeb, ce;
  logic [15:0] addr;
  logic [7:0]  idata, odata;
  logic [7:0]  mem1 [0:65535];

  // Instance 2: CE_HALF = 2
  logic        b_cmd_valid, b_cmd_wr, b_rsp_ready;
  logic [15:0] b_cmd_addr;
  logic [7:0]  b_cmd_wdata;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_wr;
  logic [7:0]  b_rsp_rdata;
  logic [15:0] b_txn_cnt;
  logic        b_csb, b_web, b_oeb, b_ce;
  logic [15:0] b_addr;
  logic [7:0]  b_idata, b_odata;
  logic [7:0]  mem2 [0:65535];

`ifdef MEMCTRL_SEQ_BIST_EN
  logic       bist_en_o, bist_pass, bist_req, bist_done, bist_result;
  logic [2:0] bist_mode_o, bist_mode;
  logic       b_bist_en_o, b_bist_done, b_bist_result;
  logic [2:0] b_bist_mode_o;
`endif

  memctrl_host_seq #(.CE_HALF(1), .AW(16), .DW(8)
`ifdef MEMCTRL_SEQ_BIST_EN
    , .BIST_LEN(8)
`endif
  ) dut1 (
    .CLK(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .txn_cnt(txn_cnt), .CSB(csb), .WEB(web), .OEB(oeb),
    .CE(ce), .ADDR(addr), .IDATA(idata), .ODATA(odata)
`ifdef MEMCTRL_SEQ_BIST_EN
    , .BIST_EN(bist_en_o), .BIST_MODE(bist_mode_o), .BIST_PASS(bist_pass), .bist_req(bist_req),
    .bist_mode(bist_mode), .bist_done(bist_done), .bist_result(bist_result)
`endif
  );

  memctrl_host_seq #(.CE_HALF(2), .AW(16), .DW(8)
`ifdef MEMCTRL_SEQ_BIST_EN
    , .BIST_LEN(8)
`endif
  ) dut2 (
    .CLK(clk), .RST(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_wr(b_cmd_wr),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_wr(b_rsp_wr), .rsp_rdata(b_rsp_rdata), .txn_cnt(b_txn_cnt), .CSB(b_csb), .WEB(b_web),
    .OEB(b_oeb), .CE(b_ce), .ADDR(b_addr), .IDATA(b_idata), .ODATA(b_odata)
`ifdef MEMCTRL_SEQ_BIST_EN
    , .BIST_EN(b_bist_en_o), .BIST_MODE(b_bist_mode_o), .BIST_PASS(1'b0), .bist_req(1'b0),
    .bist_mode(3'b000), .bist_done(b_bist_done), .bist_result(b_bist_result)
`endif
  );

  // SRAM models: write on CE rise with CSB=0/WEB=0, drive ODATA while OEB=0.
  always @(posedge ce) if (!csb && !web) mem1[addr] = idata;
  always @(posedge b_ce) if (!b_csb && !b_web) mem2[b_addr] = b_idata;
  assign odata   = !oeb   ? mem1[addr]   : 8'h00;
  assign b_odata = !b_oeb ? mem2[b_addr] : 8'h00;

  // Presents a command in one cycle; returns at the negedge of cycle 1 (SETUP).
  task automatic issue1(input logic wr, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue1_ready got=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic issue2(input logic wr, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    n_cmp++;
    if (b_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue2_ready got=%b exp=1", b_cmd_ready);
    end
    b_cmd_valid = 1'b1; b_cmd_wr = wr; b_cmd_addr = a; b_cmd_wdata = d;
    @(negedge clk);
    b_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({csb, web, oeb, ce, addr, idata} !== {4'b1110, 16'h0000, 8'h00}) begin
      n_fail++; $display("FAIL reset_pins got=%b%b%b%b %h %h exp=1110 0000 00", csb, web, oeb, ce, addr, idata);
    end
    n_cmp++;
    if ({rsp_valid, rsp_wr, rsp_rdata, txn_cnt, cmd_ready} !== {2'b00, 8'h00, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL reset_rsp got=%b %b %h %h rdy=%b exp=0 0 00 0000 rdy=0",
                         rsp_valid, rsp_wr, rsp_rdata, txn_cnt, cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || b_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready got=%b/%b exp=1/1", cmd_ready, b_cmd_ready);
    end
  endtask

  task automatic test_write();
    logic [3:0] pat;
    pat = 4'b1010;
    issue1(1'b1, 16'h1234, 8'hA5);
    n_cmp++;
    if ({csb, web, oeb, ce, addr, idata, cmd_ready} !== {4'b0010, 16'h1234, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL wr_setup got=%b%b%b%b %h %h rdy=%b exp=0010 1234 a5 rdy=0",
                         csb, web, oeb, ce, addr, idata, cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ce !== pat[3-i] || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL wr_ce_cycle%0d got ce=%b vld=%b exp ce=%b vld=0", i + 2, ce, rsp_valid, pat[3-i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_wr, rsp_rdata, csb, ce} !== {2'b11, 8'h00, 2'b10}) begin
      n_fail++; $display("FAIL wr_resp got vld=%b wr=%b rd=%h csb=%b ce=%b exp 1 1 00 1 0",
                         rsp_valid, rsp_wr, rsp_rdata, csb, ce);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, txn_cnt, cmd_ready, addr, idata} !== {1'b0, 16'd1, 1'b1, 16'h1234, 8'hA5}) begin
      n_fail++; $display("FAIL wr_done got vld=%b txn=%0d rdy=%b addr=%h idata=%h exp 0 1 1 1234 a5",
                         rsp_valid, txn_cnt, cmd_ready, addr, idata);
    end
  endtask

  task automatic test_read();
    issue1(1'b0, 16'h1234, 8'hFF);
    n_cmp++;
    if ({csb, web, oeb, ce, idata} !== {4'b0100, 8'h00}) begin
      n_fail++; $display("FAIL rd_setup got=%b%b%b%b idata=%h exp=0100 00", csb, web, oeb, ce, idata);
    end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (oeb !== (c >= 4)) begin
        n_fail++; $display("FAIL rd_oeb_cycle%0d got=%b exp=%b", c, oeb, (c >= 4));
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_wr, rsp_rdata} !== {2'b10, 8'hA5}) begin
      n_fail++; $display("FAIL rd_resp got vld=%b wr=%b rd=%h exp 1 0 a5", rsp_valid, rsp_wr, rsp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (txn_cnt !== 16'd2 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_done got txn=%0d rdy=%b exp 2 1", txn_cnt, cmd_ready);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue1(1'b0, 16'h1234, 8'h00);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({rsp_valid, rsp_wr, rsp_rdata, cmd_ready, csb, ce} !== {2'b10, 8'hA5, 1'b0, 2'b10}) begin
        n_fail++; $display("FAIL bp_hold%0d got vld=%b wr=%b rd=%h rdy=%b exp 1 0 a5 0",
                           k, rsp_valid, rsp_wr, rsp_rdata, cmd_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL bp_fourth got vld=%b rd=%h exp 1 a5", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || txn_cnt !== 16'd3) begin
      n_fail++; $display("FAIL bp_release got rdy=%b vld=%b txn=%0d exp 1 0 3", cmd_ready, rsp_valid, txn_cnt);
    end
  endtask

  task automatic test_back_to_back();
    // Command presented in the very cycle cmd_ready reasserts.
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0010; cmd_wdata = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({csb, web, oeb, ce, addr, idata} !== {4'b0010, 16'h0010, 8'h5A}) begin
      n_fail++; $display("FAIL b2b_setup got=%b%b%b%b %h %h exp=0010 0010 5a", csb, web, oeb, ce, addr, idata);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1) begin
      n_fail++; $display("FAIL b2b_resp got vld=%b wr=%b exp 1 1", rsp_valid, rsp_wr);
    end
    @(negedge clk);
    n_cmp++;
    if (txn_cnt !== 16'd4 || mem1[16'h0010] !== 8'h5A) begin
      n_fail++; $display("FAIL b2b_done got txn=%0d mem=%h exp 4 5a", txn_cnt, mem1[16'h0010]);
    end
  endtask

  task automatic test_ce_half2();
    logic [7:0] pat;
    pat = 8'b1100_1100;
    issue2(1'b1, 16'hFFFF, 8'h3C);
    n_cmp++;
    if ({b_csb, b_web, b_oeb, b_ce, b_addr, b_idata} !== {4'b0010, 16'hFFFF, 8'h3C}) begin
      n_fail++; $display("FAIL h2_wr_setup got=%b%b%b%b %h %h exp=0010 ffff 3c", b_csb, b_web, b_oeb, b_ce, b_addr, b_idata);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b_ce !== pat[7-i] || b_rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL h2_ce_cycle%0d got ce=%b vld=%b exp ce=%b vld=0", i + 2, b_ce, b_rsp_valid, pat[7-i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (b_rsp_valid !== 1'b1 || b_rsp_wr !== 1'b1 || b_rsp_rdata !== 8'h00) begin
      n_fail++; $display("FAIL h2_wr_resp got vld=%b wr=%b rd=%h exp 1 1 00", b_rsp_valid, b_rsp_wr, b_rsp_rdata);
    end
    issue2(1'b0, 16'hFFFF, 8'h00);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (b_oeb !== 1'b0) begin
      n_fail++; $display("FAIL h2_oeb_cycle5 got=%b exp=0", b_oeb);
    end
    @(negedge clk);
    n_cmp++;
    if (b_oeb !== 1'b1) begin
      n_fail++; $display("FAIL h2_oeb_cycle6 got=%b exp=1", b_oeb);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (b_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL h2_rd_cycle9 got vld=%b exp 0", b_rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({b_rsp_valid, b_rsp_wr, b_rsp_rdata} !== {2'b10, 8'h3C}) begin
      n_fail++; $display("FAIL h2_rd_resp got vld=%b wr=%b rd=%h exp 1 0 3c", b_rsp_valid, b_rsp_wr, b_rsp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (b_txn_cnt !== 16'd2) begin
      n_fail++; $display("FAIL h2_txn got=%0d exp=2", b_txn_cnt);
    end
  endtask

  task automatic test_reset_mid();
    issue1(1'b1, 16'h0042, 8'h77);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ce !== 1'b0 || csb !== 1'b1) begin
      n_fail++; $display("FAIL rm_ce1l got ce=%b csb=%b exp 0 1", ce, csb);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({csb, web, oeb, ce, addr, idata, rsp_valid, rsp_rdata, txn_cnt, cmd_ready}
        !== {4'b1110, 16'h0000, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL rm_reset got=%b%b%b%b %h %h vld=%b rd=%h txn=%0d rdy=%b exp=1110 0000 00 0 00 0 0",
                         csb, web, oeb, ce, addr, idata, rsp_valid, rsp_rdata, txn_cnt, cmd_ready);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || ce !== 1'b0 || cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL rm_quiet%0d got vld=%b ce=%b rdy=%b exp 0 0 1", k, rsp_valid, ce, cmd_ready);
      end
    end
    issue1(1'b0, 16'h1234, 8'h00);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL rm_next_rd got vld=%b rd=%h exp 1 a5", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (txn_cnt !== 16'd1) begin
      n_fail++; $display("FAIL rm_next_txn got=%0d exp=1", txn_cnt);
    end
  endtask

`ifdef MEMCTRL_SEQ_BIST_EN
  task automatic test_bist();
    @(negedge clk);
    bist_req = 1'b1; bist_mode = 3'b010; bist_pass = 1'b1;
    @(negedge clk);
    bist_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if (bist_en_o !== 1'b1 || bist_mode_o !== 3'd2 || cmd_ready !== 1'b0 || bist_done !== 1'b0) begin
        n_fail++; $display("FAIL bist_run%0d got en=%b mode=%0d rdy=%b done=%b exp 1 2 0 0",
                           k, bist_en_o, bist_mode_o, cmd_ready, bist_done);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bist_en_o !== 1'b0 || bist_done !== 1'b1 || bist_result !== 1'b1 || txn_cnt !== 16'd1) begin
      n_fail++; $display("FAIL bist_end got en=%b done=%b res=%b txn=%0d exp 0 1 1 1",
                         bist_en_o, bist_done, bist_result, txn_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (bist_done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL bist_after got done=%b rdy=%b exp 0 1", bist_done, cmd_ready);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    b_cmd_valid = 1'b0; b_cmd_wr = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0; b_rsp_ready = 1'b1;
`ifdef MEMCTRL_SEQ_BIST_EN
    bist_req = 1'b0; bist_mode = 3'b000; bist_pass = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_ce_half2();
    test_reset_mid();
`ifdef MEMCTRL_SEQ_BIST_EN
    test_bist();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
